regfile_read_dump: RTL and testbench

32-entry x 32-bit register file for the CPU datapath.
- One synchronous write port and two asynchronous read ports; entry 0 is hardwired to zero.
- A sequential dump engine streams every entry out over a valid/ready interface for debug and test readback.
- The block is the read-side counterpart to the per-entry write-enabled storage registers: it owns address decode, read muxing and ordered readout.

---
 rtl/regfile_read_dump.sv | 123 ++++++++++++
 tb/tb_regfile_read_dump.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_dump.sv
`timescale 1ns/1ps
// regfile_read_dump: 32x32 register file with one synchronous write port,
// two combinational read ports (entry 0 reads as zero) and a sequential
// valid/ready dump engine that streams every entry out in address order.
// Optional build macro: REGFILE_WRITE_BYPASS_EN enables write-to-read
// forwarding on both read ports and on the dump engine's LOAD read.
module regfile_read_dump #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             dump_start,
    input  logic             dump_ready,
    output logic             dump_valid,
    output logic [AW-1:0]    dump_addr,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_busy,
    output logic             dump_done
);

    typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    // Shared read rule: entry 0 is zero, optional forwarding of the
    // write happening in this same cycle, otherwise the stored value.
    function automatic logic [WIDTH-1:0] read_entry(input logic [AW-1:0] addr);
        if (addr == '0)
            return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (wr_en && (wr_addr == addr))
            return wr_data;
`endif
        return mem[addr];
    endfunction

    // Combinational read ports
    always_comb begin
        rd_data_a = read_entry(rd_addr_a);
        rd_data_b = read_entry(rd_addr_b);
    end

    assign dump_busy = (state != IDLE);

    // Storage: reset clears every entry; writes to address 0 are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; a start coinciding with the done pulse is the tail
    // of the previous dump and is not taken as a new request
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (dump_start && !dump_done) state_next = LOAD;
            LOAD: state_next = SHOW;
            SHOW: if (dump_ready) state_next = (ptr == LAST) ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Dump datapath: capture a beat in LOAD, hold it in SHOW until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump_start && !dump_done)
                        ptr <= '0;
                end
                LOAD: begin
                    dump_data  <= read_entry(ptr);
                    dump_addr  <= ptr;
                    dump_valid <= 1'b1;
                end
                SHOW: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (ptr == LAST)
                            dump_done <= 1'b1;
                        else
                            ptr <= ptr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_read_dump.sv
`timescale 1ns/1ps
// Directed self-checking bench for regfile_read_dump.
module tb_regfile_read_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        dump_start;
    logic        dump_ready;
    logic        dump_valid;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        dump_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_read_dump #(.WIDTH(32), .DEPTH(32), .AW(5)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic rd_both(input string tag, input logic [4:0] a, input logic [31:0] exp);
        rd_addr_a = a;
        rd_addr_b = a;
        @(negedge clk);
        chk({tag, "_a"}, rd_data_a, exp);
        chk({tag, "_b"}, rd_data_b, exp);
    endtask

    // Runs one dump. stall_at >= 0: hold ready low 5 cycles on that beat while
    // rewriting the entry and re-pulsing start. reset_at >= 0: reset on that beat.
    task automatic run_dump(input int stall_at, input int reset_at);
        int n      = 0;
        int load_n = -1;
        int done_n = -1;
        int dones  = 0;
        int beat   = 0;
        int stalls = 0;
        bit fin    = 1'b0;
        bit rst_hit = 1'b0;
        bit seen_done = 1'b0;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        n = 1;
        dump_start = 1'b0;
        chk("busy_after_start", {31'b0, dump_busy}, 32'd1);
        while (!fin && n < 400) begin
            if (load_n < 0 && dump_busy && !dump_valid) load_n = n;
            wr_en = 1'b0;
            dump_start = 1'b0;
            dump_ready = 1'b1;
            if (dump_done) begin
                dones++;
                done_n = n;
                dump_start = 1'b1;
                fin = 1'b1;
            end else if (dump_valid && reset_at >= 0 && dump_addr == 5'(reset_at)) begin
                reset = 1'b1;
                dump_ready = 1'b0;
                rst_hit = 1'b1;
                fin = 1'b1;
            end else if (dump_valid && stall_at >= 0 && dump_addr == 5'(stall_at) && stalls < 5) begin
                dump_ready = 1'b0;
                wr_en   = 1'b1;
                wr_addr = 5'(stall_at);
                wr_data = 32'hFFFF_FFFF;
                dump_start = 1'b1;
                chk("stall_data", dump_data, 32'(stall_at * 3));
                chk("stall_busy", {31'b0, dump_busy}, 32'd1);
                stalls++;
            end else if (dump_valid) begin
                chk("beat_addr", {27'b0, dump_addr}, 32'(beat));
                chk("beat_data", dump_data, 32'(beat * 3));
                beat++;
            end
            step();
            n++;
        end
        wr_en = 1'b0;
        dump_start = 1'b0;
        if (!fin) begin
            chk("dump_timeout", 32'd0, 32'd1);
        end else if (rst_hit) begin
            reset = 1'b0;
            chk("rst_valid", {31'b0, dump_valid}, 32'd0);
            chk("rst_busy", {31'b0, dump_busy}, 32'd0);
            for (int i = 0; i < 6; i++) begin
                if (dump_done) seen_done = 1'b1;
                step();
            end
            chk("rst_no_done", {31'b0, seen_done}, 32'd0);
            chk("rst_beats_before", 32'(beat), 32'(reset_at));
            for (int i = 0; i < 32; i++) rd_both("rst_entry", 5'(i), 32'd0);
        end else begin
            chk("start_on_done_ignored", {31'b0, dump_busy}, 32'd0);
            chk("done_one_cycle", {31'b0, dump_done}, 32'd0);
            chk("done_count", 32'(dones), 32'd1);
            chk("beat_count", 32'(beat), 32'd32);
            chk("first_load_cycle", 32'(load_n), 32'd1);
            chk("load_to_done", 32'(done_n - load_n), (stall_at >= 0) ? 32'd69 : 32'd64);
            if (stall_at >= 0) chk("stall_count", 32'(stalls), 32'd5);
        end
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("reset_valid", {31'b0, dump_valid}, 32'd0);
        chk("reset_busy", {31'b0, dump_busy}, 32'd0);
        chk("reset_done", {31'b0, dump_done}, 32'd0);
        for (int i = 0; i < 32; i++) rd_both("reset_entry", 5'(i), 32'd0);

        // Basic write, address 0 discarded
        step();
        wr(5'd5, 32'hDEAD_BEEF);
        wr(5'd0, 32'h1234_5678);
        rd_both("wr5", 5'd5, 32'hDEAD_BEEF);
        rd_both("wr0", 5'd0, 32'd0);
        rd_both("wr6_untouched", 5'd6, 32'd0);

        // Same-cycle write and read of address 7, and address 0 never forwarded
        step();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
        rd_addr_a = 5'd7; rd_addr_b = 5'd0;
        @(negedge clk);
`ifdef REGFILE_WRITE_BYPASS_EN
        chk("same_cycle_a", rd_data_a, 32'hA5A5_A5A5);
`else
        chk("same_cycle_a", rd_data_a, 32'd0);
`endif
        chk("same_cycle_b0", rd_data_b, 32'd0);
        step();
        wr_en = 1'b0;
        rd_both("next_cycle7", 5'd7, 32'hA5A5_A5A5);
        step();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h5555_AAAA; rd_addr_a = 5'd0;
        @(negedge clk);
        chk("no_fwd_addr0", rd_data_a, 32'd0);
        step();
        wr_en = 1'b0;

        // entry[i] = i*3
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 3));
        rd_both("load31", 5'd31, 32'd93);

        // Full dump with ready held high
        run_dump(-1, -1);

        // Dump with a 5-cycle stall on beat 10 and a rewrite of entry 10
        step();
        run_dump(10, -1);
        rd_both("rewrite10", 5'd10, 32'hFFFF_FFFF);

        // Reset during beat 20
        wr(5'd10, 32'd30);
        step();
        run_dump(-1, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
